// File: rtl/pipe_hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package pipe_hazard_pkg;

  typedef enum logic {
    IDLE       = 1'b0,
    EXCP_FLUSH = 1'b1
  } hz_state_e;

  localparam int FETCH  = 0;
  localparam int DECODE = 1;

  localparam int NUM_STAGES_DEF = 5;
  localparam int BR_STAGE_DEF   = 2;
  localparam int EXCP_STAGE_DEF = 3;
  localparam int EXCP_HOLD_DEF  = 2;
  localparam int CNT_W_DEF      = 16;

endpackage

// File: rtl/pipe_hazard_perf.sv
// Saturating performance counters: stalled fetch cycles and redirect pulses.
module pipe_hazard_perf #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_evt,
  input  logic             redirect_evt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_evt && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (redirect_evt && (flush_events != '1))
        flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: backpressure stalls, branch/exception flushes, load-use bubbles.
// Optional perf counters are enabled by defining PIPE_HAZARD_CTRL_PERF_EN.
//   state      | meaning
//   IDLE       | no exception flush in progress
//   EXCP_FLUSH | holding front-end flush for remaining exception cycles
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int BR_STAGE   = BR_STAGE_DEF,
  parameter int EXCP_STAGE = EXCP_STAGE_DEF,
  parameter int EXCP_HOLD  = EXCP_HOLD_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in_brTaken,
  input  logic                  io_in_excpValid,
  input  logic                  io_in_loadUse,
  input  logic [NUM_STAGES-1:0] io_in_stallReq,
  output logic [NUM_STAGES-1:0] io_out_flush,
  output logic [NUM_STAGES-1:0] io_out_stall,
  output logic                  io_out_redirect,
  output logic                  io_out_busy
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]      io_perf_stallCycles,
  output logic [CNT_W-1:0]      io_perf_flushEvents
`endif
);

  localparam int CW = $clog2(EXCP_HOLD) + 1;

  hz_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [NUM_STAGES-1:0] stall_raw;
  logic [NUM_STAGES-1:0] flush_c;
  logic                  excp_act;
  logic                  br_issue;
  logic                  lu_bubble;

  // A stall anywhere downstream backs up every earlier stage.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      stall_raw[i] = |(io_in_stallReq >> i);
      if (i <= DECODE)
        stall_raw[i] = stall_raw[i] | io_in_loadUse;
    end
  end

  assign excp_act  = io_in_excpValid || (state_q == EXCP_FLUSH);
  assign br_issue  = (io_in_brTaken || pend_q) && !stall_raw[BR_STAGE] && !excp_act;
  assign lu_bubble = io_in_loadUse && !stall_raw[2];

  always_comb begin
    flush_c = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (excp_act && (i <= EXCP_STAGE)) flush_c[i] = 1'b1;
      if (br_issue && (i < BR_STAGE))    flush_c[i] = 1'b1;
    end
    flush_c[2] = flush_c[2] | lu_bubble;
  end

  always_comb begin
    io_out_flush    = flush_c;
    io_out_stall    = stall_raw & ~flush_c;
    io_out_redirect = io_in_excpValid || br_issue;
    io_out_busy     = (state_q != IDLE) || pend_q;
    if (reset) begin
      io_out_flush    = '1;
      io_out_stall    = '0;
      io_out_redirect = 1'b0;
      io_out_busy     = 1'b0;
    end
  end

  // Exceptions win over any branch, pending or new.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    if (io_in_excpValid) begin
      pend_d = 1'b0;
      if (EXCP_HOLD > 1) begin
        state_d = EXCP_FLUSH;
        cnt_d   = CW'(EXCP_HOLD - 1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end else if (state_q == EXCP_FLUSH) begin
      pend_d = 1'b0;
      if (cnt_q <= CW'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (pend_q) begin
      if (!stall_raw[BR_STAGE]) pend_d = 1'b0;
    end else if (io_in_brTaken && stall_raw[BR_STAGE]) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  pipe_hazard_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clock        (clock),
    .reset        (reset),
    .stall_evt    (io_out_stall[FETCH]),
    .redirect_evt (io_out_redirect),
    .stall_cycles (io_perf_stallCycles),
    .flush_events (io_perf_flushEvents)
  );
`else
  logic unused_perf_cfg;
  assign unused_perf_cfg = (CNT_W > 0) && (FETCH == 0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl; builds with or without PIPE_HAZARD_CTRL_PERF_EN.
module tb_pipe_hazard_ctrl;

  localparam int NS    = 5;
  localparam int BR    = 2;
  localparam int EX    = 3;
  localparam int HOLD  = 2;
  localparam int CNT_W = 2;

  logic          clock;
  logic          reset;
  logic          br_taken, excp_valid, load_use;
  logic [NS-1:0] stall_req;
  logic [NS-1:0] flush, stall;
  logic          redirect, busy;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall, perf_flush;
`endif

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(
    .NUM_STAGES (NS),
    .BR_STAGE   (BR),
    .EXCP_STAGE (EX),
    .EXCP_HOLD  (HOLD),
    .CNT_W      (CNT_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .io_in_brTaken   (br_taken),
    .io_in_excpValid (excp_valid),
    .io_in_loadUse   (load_use),
    .io_in_stallReq  (stall_req),
    .io_out_flush    (flush),
    .io_out_stall    (stall),
    .io_out_redirect (redirect),
    .io_out_busy     (busy)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .io_perf_stallCycles (perf_stall),
    .io_perf_flushEvents (perf_flush)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  // Behavioural model: remaining forced-flush cycles and a waiting-branch flag.
  int hold_rem = 0;
  bit br_wait  = 1'b0;
  int sc_cnt = 0, fe_cnt = 0;

  always @(negedge clock) begin : cmp
    logic [NS-1:0] es, ef;
    logic er, eb, exc_now, br_go;
    int sat;
    sat = (1 << CNT_W) - 1;
    if (reset) begin
      chk("m_flush", 32'(flush), 32'h1f);
      chk("m_stall", 32'(stall), 0);
      chk("m_redir", 32'(redirect), 0);
      chk("m_busy", 32'(busy), 0);
      hold_rem = 0;
      br_wait  = 1'b0;
      sc_cnt   = 0;
      fe_cnt   = 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        es[i] = 1'b0;
        for (int j = i; j < NS; j++) es[i] = es[i] | stall_req[j];
        if (i < 2) es[i] = es[i] | load_use;
      end
      exc_now = excp_valid || (hold_rem > 0);
      br_go   = (br_taken || br_wait) && !es[BR] && !exc_now;
      ef = '0;
      for (int i = 0; i < NS; i++) begin
        if (exc_now && i <= EX) ef[i] = 1'b1;
        if (br_go && i < BR)    ef[i] = 1'b1;
      end
      if (load_use && !es[2]) ef[2] = 1'b1;
      er = excp_valid || br_go;
      eb = (hold_rem > 0) || br_wait;
      chk("m_flush", 32'(flush), 32'(ef));
      chk("m_stall", 32'(stall), 32'(es & ~ef));
      chk("m_redir", 32'(redirect), 32'(er));
      chk("m_busy", 32'(busy), 32'(eb));
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk("m_perf_stall", 32'(perf_stall), 32'(sc_cnt < sat ? sc_cnt : sat));
      chk("m_perf_flush", 32'(perf_flush), 32'(fe_cnt < sat ? fe_cnt : sat));
`endif
      if ((es[0] && !ef[0])) sc_cnt++;
      if (er) fe_cnt++;
      if (excp_valid) begin
        hold_rem = HOLD - 1;
        br_wait  = 1'b0;
      end else if (hold_rem > 0) begin
        hold_rem--;
        br_wait = 1'b0;
      end else if (br_wait) begin
        if (!es[BR]) br_wait = 1'b0;
      end else if (br_taken && es[BR]) begin
        br_wait = 1'b1;
      end
    end
  end

  task automatic cyc(input logic rst, input logic br, input logic ex, input logic lu,
                     input logic [NS-1:0] req);
    @(posedge clock);
    #1;
    reset      = rst;
    br_taken   = br;
    excp_valid = ex;
    load_use   = lu;
    stall_req  = req;
  endtask

  task automatic neg();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; br_taken = 0; excp_valid = 0; load_use = 0; stall_req = 5'b11111;
    neg();
    chk("rst_flush", 32'(flush), 32'h1f);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_redir", 32'(redirect), 0);
    cyc(1, 0, 0, 0, 5'b11111);
    cyc(0, 0, 0, 0, 5'b00000); neg();
    chk("idle_flush", 32'(flush), 0);
    chk("idle_busy", 32'(busy), 0);

    cyc(0, 1, 0, 0, 5'b00000); neg();
    chk("br_flush", 32'(flush), 32'b00011);
    chk("br_redir", 32'(redirect), 1);
    cyc(0, 0, 0, 0, 5'b00000); neg();
    chk("br_after_flush", 32'(flush), 0);

    cyc(0, 1, 0, 0, 5'b01000); neg();
    chk("defer_flush", 32'(flush), 0);
    chk("defer_stall", 32'(stall), 32'b01111);
    cyc(0, 1, 0, 0, 5'b01000); neg();
    chk("defer_busy", 32'(busy), 1);
    chk("defer_redir", 32'(redirect), 0);
    cyc(0, 0, 0, 0, 5'b01000);
    cyc(0, 0, 0, 0, 5'b00000); neg();
    chk("pend_flush", 32'(flush), 32'b00011);
    chk("pend_redir", 32'(redirect), 1);
    cyc(0, 0, 0, 0, 5'b00000); neg();
    chk("pend_clear", 32'(busy), 0);

    cyc(0, 0, 1, 0, 5'b11111); neg();
    chk("excp_flush", 32'(flush), 32'b01111);
    chk("excp_stall", 32'(stall), 32'b10000);
    chk("excp_redir", 32'(redirect), 1);
    cyc(0, 1, 0, 0, 5'b00000); neg();
    chk("hold_flush", 32'(flush), 32'b01111);
    chk("hold_redir", 32'(redirect), 0);
    cyc(0, 0, 0, 0, 5'b00000); neg();
    chk("hold_done", 32'(flush), 0);
    chk("br_discard", 32'(busy), 0);

    cyc(0, 0, 0, 1, 5'b00000); neg();
    chk("lu_stall", 32'(stall), 32'b00011);
    chk("lu_flush", 32'(flush), 32'b00100);

    cyc(0, 0, 1, 0, 5'b00000);
    cyc(0, 0, 1, 0, 5'b00000); neg();
    chk("restart_redir", 32'(redirect), 1);
    cyc(0, 0, 0, 0, 5'b00000); neg();
    chk("restart_hold", 32'(flush), 32'b01111);
    cyc(0, 0, 0, 0, 5'b00000);

    cyc(0, 1, 0, 0, 5'b00100);
    cyc(0, 0, 1, 0, 5'b00100);
    cyc(0, 0, 0, 0, 5'b00000);
    cyc(0, 0, 0, 0, 5'b00000); neg();
    chk("pend_killed", 32'(flush), 0);

    cyc(0, 0, 1, 0, 5'b00000);
    cyc(1, 0, 0, 0, 5'b11111); neg();
    chk("midrst_flush", 32'(flush), 32'h1f);
    chk("midrst_stall", 32'(stall), 0);
    cyc(0, 0, 0, 0, 5'b00000); neg();
    chk("postrst_flush", 32'(flush), 0);
    chk("postrst_busy", 32'(busy), 0);

    cyc(0, 1, 0, 0, 5'b01000);
    cyc(1, 0, 0, 0, 5'b00000);
    cyc(0, 0, 0, 0, 5'b00000); neg();
    chk("rst_pend_busy", 32'(busy), 0);

    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 5'b00001);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    neg();
    chk("perf_sat", 32'(perf_stall), 3);
`endif

    for (int k = 0; k < 60; k++) begin
      logic [NS-1:0] r;
      r = NS'($urandom_range(0, 31)) & NS'($urandom_range(0, 31));
      cyc(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), r);
    end
    cyc(0, 0, 0, 0, 5'b00000);
    neg();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 5, pipeline depth; stage 0 = fetch, 1 = decode; minimum 3.
REQ-002 Parameter BR_STAGE, default 2, stage that resolves branches; range 2..NUM_STAGES-1.
REQ-003 Parameter EXCP_STAGE, default 3, stage that raises exceptions; range BR_STAGE..NUM_STAGES-1.
REQ-004 Parameter EXCP_HOLD, default 2, total cycles flush is held per exception; minimum 1.
REQ-005 Parameter CNT_W, default 16, perf-counter width.
REQ-006 clock  input  1  sole clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 io_in_brTaken  input  1  branch at BR_STAGE is taken this cycle.
REQ-009 io_in_excpValid  input  1  exception at EXCP_STAGE this cycle.
REQ-010 io_in_loadUse  input  1  load-use hazard detected at decode.
REQ-011 io_in_stallReq  input  NUM_STAGES  per-stage stall request; bit i = stage i cannot advance.
REQ-012 io_out_flush  output  NUM_STAGES  per-stage flush; bit i invalidates stage i's register.
REQ-013 io_out_stall  output  NUM_STAGES  per-stage hold.
REQ-014 io_out_redirect  output  1  one-cycle pulse; fetch takes the new target.
REQ-015 io_out_busy  output  1  high when the FSM is not IDLE or a branch is pending.

Function
REQ-016 Backpressure stall: stall_raw[i] = OR of stallReq[j] for j >= i; for i <= 1, also OR loadUse.
REQ-017 Output stall: io_out_stall[i] = stall_raw[i] AND NOT io_out_flush[i]; flush dominates stall.
REQ-018 FSM states: IDLE and EXCP_FLUSH; a down-counter holds the remaining hold cycles.
REQ-019 excpValid in any state: flush[i] = 1 for all i <= EXCP_STAGE in the same cycle (combinational); redirect = 1; pending branch cleared.
REQ-020 After excpValid, if EXCP_HOLD > 1: enter EXCP_FLUSH with counter = EXCP_HOLD-1.
REQ-021 In EXCP_FLUSH: flush[i] = 1 for i <= EXCP_STAGE; redirect = 0; counter decrements; return to IDLE when the counter reaches 1 at the edge.
REQ-022 excpValid during EXCP_FLUSH restarts the counter at EXCP_HOLD-1 and pulses redirect again.
REQ-023 Branch issue: brTaken with stall_raw[BR_STAGE] = 0 and no exception activity gives flush[i] = 1 for i < BR_STAGE and redirect = 1 in the same cycle.
REQ-024 Branch deferral: brTaken with stall_raw[BR_STAGE] = 1 sets the pending-branch register; no flush yet.
REQ-025 Pending branch issue: in the first cycle with stall_raw[BR_STAGE] = 0, flush and redirect are issued as in REQ-023, then pending clears.
REQ-026 brTaken while a branch is already pending is ignored; it is the same held instruction.
REQ-027 brTaken or a pending branch while excpValid or EXCP_FLUSH is active is discarded; exception has priority.
REQ-028 Load-use bubble: loadUse = 1 and stall_raw[2] = 0 gives flush[2] = 1, inserting a bubble; stages 0..1 stall.
REQ-029 Flush bits from REQ-019..028 are ORed per stage.
REQ-030 No latency other than the deferral and hold state above; all outputs are combinational from inputs and state.

Reset
REQ-031 While reset = 1: io_out_flush = all ones, io_out_stall = 0, io_out_redirect = 0, io_out_busy = 0.
REQ-032 Reset sets FSM = IDLE, counter = 0 and pending = 0, and clears perf counters.
REQ-033 Reset asserted mid EXCP_FLUSH or with a branch pending abandons that state; the first cycle after reset is IDLE.

Configuration
REQ-034 Macro PIPE_HAZARD_CTRL_PERF_EN defined: adds outputs io_perf_stallCycles (CNT_W) and io_perf_flushEvents (CNT_W).
REQ-035 io_perf_stallCycles counts cycles with stall[0] = 1.
REQ-036 io_perf_flushEvents counts redirect pulses.
REQ-037 Both perf counters saturate at all ones.
REQ-038 Macro undefined: no perf ports and no perf logic; all other behaviour is identical.

Structure
REQ-039 Shared package pipe_hazard_pkg holds the FSM state enum, stage-index constants (FETCH=0, DECODE=1) and the parameter defaults.
REQ-040 Optional sub-module pipe_hazard_perf holds the saturating counters, instantiated only under PIPE_HAZARD_CTRL_PERF_EN.

Verification
REQ-041 Defaults; brTaken=1 for one cycle, no stalls -> same cycle flush=5'b00011, redirect=1; next cycle flush=0.
REQ-042 stallReq=5'b01000 for 3 cycles; brTaken in cycle 1 -> no flush during the stall; flush=5'b00011 and redirect in the first unstalled cycle; busy=1 while pending.
REQ-043 excpValid=1 for one cycle -> flush=5'b01111 for 2 cycles; redirect in the first cycle only; brTaken in the second cycle is discarded.
REQ-044 loadUse=1, no stallReq -> stall=5'b00011, flush=5'b00100.
REQ-045 Reset asserted during EXCP_FLUSH -> flush=5'b11111 and stall=0 while reset; IDLE and flush=0 after release.
REQ-046 PERF_EN defined, CNT_W=2, stall held for 6 cycles -> io_perf_stallCycles saturates at 3.
